// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: two-requester arbiter for the shared
// HyperRAM read port, round-robin with burst limit.
module dma_rd_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_en_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_rd_i,
  output logic        m0_busy_o,
  output logic        m0_rdata_rdy_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_en_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_rd_i,
  output logic        m1_busy_o,
  output logic        m1_rdata_rdy_o,
  output logic [31:0] m1_rdata_o,
  output logic        ram_rd_o,
  output logic [31:0] ram_addr_o,
  input  logic        ram_busy_i,
  input  logic        ram_rdata_rdy_i,
  input  logic [31:0] ram_rdata_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic        own_q, own_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;

  logic        own_en;
  logic        own_rd;
  logic [31:0] own_addr;
  logic        rd_ok;
  logic [7:0]  cnt_inc;
  logic        in_grant;
  logic        in_wait;

  assign own_en   = own_q ? m1_en_i : m0_en_i;
  assign own_rd   = own_q ? m1_rd_i : m0_rd_i;
  assign own_addr = own_q ? m1_addr_i : m0_addr_i;
  assign rd_ok    = own_rd & ~ram_busy_i;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q
                                     : cnt_q + 8'd1;

  // State and bookkeeping registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: grant, issue one read, wait, then
  // continue the burst or release to the other side.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_en_i | m1_en_i) begin
          own_d   = (m0_en_i & m1_en_i) ? ptr_q
                                        : m1_en_i;
          grant_d = own_d ? 2'b10 : 2'b01;
          cnt_d   = 8'd0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (rd_ok) begin
          addr_d  = own_addr;
          state_d = S_ISSUE;
        end else if (!own_en) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = ~own_q;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ram_rdata_rdy_i) begin
          cnt_d = cnt_inc;
          if (own_en && (cnt_inc < MAX_B)) begin
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            ptr_d   = ~own_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Outputs are forced to reset values while resetn is low.
  always_comb begin
    in_grant = resetn && (state_q == S_GRANT);
    in_wait  = resetn && (state_q == S_WAIT);
    m0_busy_o = (in_grant && !own_q) ? ram_busy_i
                                     : 1'b1;
    m1_busy_o = (in_grant && own_q) ? ram_busy_i
                                    : 1'b1;
    m0_rdata_rdy_o = in_wait && !own_q
                     && ram_rdata_rdy_i;
    m1_rdata_rdy_o = in_wait && own_q
                     && ram_rdata_rdy_i;
    m0_rdata_o = ram_rdata_i;
    m1_rdata_o = ram_rdata_i;
    ram_rd_o   = resetn && (state_q == S_ISSUE);
    ram_addr_o = resetn ? addr_q : 32'd0;
    grant_o    = resetn ? grant_q : 2'b00;
  end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb_dma_rd_arbiter: directed stimulus, queue-based
// scoreboard for ram_rd and rdata_rdy events.
module tb_dma_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_en_i = 1'b0, m1_en_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
  logic        m0_rd_i = 1'b0, m1_rd_i = 1'b0;
  logic        m0_busy_o, m1_busy_o;
  logic        m0_rdata_rdy_o, m1_rdata_rdy_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_rd_o;
  logic [31:0] ram_addr_o;
  logic        ram_busy_i = 1'b0;
  logic        ram_rdata_rdy_i = 1'b0;
  logic [31:0] ram_rdata_i = '0;
  logic [1:0]  grant_o;

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;

  logic [31:0] exp_rd[$];
  logic [32:0] exp_dat[$];

  dma_rd_arbiter #(.MAX_BURST(16)) dut (
    .clk(clk), .resetn(resetn),
    .m0_en_i(m0_en_i), .m0_addr_i(m0_addr_i),
    .m0_rd_i(m0_rd_i), .m0_busy_o(m0_busy_o),
    .m0_rdata_rdy_o(m0_rdata_rdy_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_en_i(m1_en_i), .m1_addr_i(m1_addr_i),
    .m1_rd_i(m1_rd_i), .m1_busy_o(m1_busy_o),
    .m1_rdata_rdy_o(m1_rdata_rdy_o),
    .m1_rdata_o(m1_rdata_o),
    .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o),
    .ram_busy_i(ram_busy_i),
    .ram_rdata_rdy_i(ram_rdata_rdy_i),
    .ram_rdata_i(ram_rdata_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               name, got, exp);
    end
  endtask

  // Monitor: every ram_rd pulse and rdata_rdy pulse
  // must match the next queued expectation.
  always @(negedge clk) begin
    if (ram_rd_o) begin
      rd_seen++;
      if (exp_rd.size() == 0) begin
        chk("ram_rd_unexpected", {1'b0, ram_addr_o},
            33'h1_FFFF_FFFF);
      end else begin
        chk("ram_addr", {1'b0, ram_addr_o},
            {1'b0, exp_rd.pop_front()});
      end
    end
    if (m0_rdata_rdy_o || m1_rdata_rdy_o) begin
      if (exp_dat.size() == 0) begin
        chk("rdata_rdy_unexpected",
            {31'd0, m1_rdata_rdy_o, m0_rdata_rdy_o},
            33'd0);
      end else if (m0_rdata_rdy_o && m1_rdata_rdy_o) begin
        chk("rdata_rdy_both", 33'd3, 33'd1);
        void'(exp_dat.pop_front());
      end else begin
        chk("rdata", {m1_rdata_rdy_o,
                      m1_rdata_rdy_o ? m1_rdata_o
                                     : m0_rdata_o},
            exp_dat.pop_front());
      end
    end
  end

  function automatic logic bsy(input logic m);
    return m ? m1_busy_o : m0_busy_o;
  endfunction

  task automatic wait_owner(input logic m,
                            output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (bsy(m) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("owner_timeout", 33'd0, 33'd1);
  endtask

  task automatic do_read(input logic m,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input int lat,
                         input bit drop);
    bit ok;
    wait_owner(m, ok);
    if (!ok) return;
    chk("grant_own", {31'd0, grant_o},
        m ? 33'd2 : 33'd1);
    exp_rd.push_back(a);
    exp_dat.push_back({m, d});
    if (m) begin
      m1_rd_i = 1'b1; m1_addr_i = a;
    end else begin
      m0_rd_i = 1'b1; m0_addr_i = a;
    end
    @(posedge clk); #1;
    m0_rd_i = 1'b0; m1_rd_i = 1'b0;
    if (drop) begin
      if (m) m1_en_i = 1'b0;
      else m0_en_i = 1'b0;
    end
    repeat (lat) @(posedge clk);
    #1;
    ram_rdata_rdy_i = 1'b1;
    ram_rdata_i = d;
    @(posedge clk); #1;
    ram_rdata_rdy_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    m0_en_i = 1'b0; m1_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    bit ok;
    int n0;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {31'd0, grant_o}, 33'd0);
    chk("rst_busy", {31'd0, m1_busy_o, m0_busy_o},
        33'd3);
    chk("rst_ram_rd", {32'd0, ram_rd_o}, 33'd0);
    chk("rst_addr", {1'b0, ram_addr_o}, 33'd0);
    resetn = 1'b1;

    // single requester
    m0_en_i = 1'b1;
    do_read(1'b0, 32'h100, 32'hA5A5_A5A5, 5, 1'b0);
    m0_en_i = 1'b0;
    @(posedge clk); #1;
    chk("single_release", {31'd0, grant_o}, 33'd0);

    // contention from reset
    do_reset();
    m0_en_i = 1'b1; m1_en_i = 1'b1;
    for (int i = 0; i < 16; i++)
      do_read(1'b0, 32'h1000 + i, 32'hC000 + i, 2, 1'b0);
    chk("burst0_idle", {31'd0, grant_o}, 33'd0);
    chk("burst0_busy", {31'd0, m1_busy_o, m0_busy_o},
        33'd3);
    @(posedge clk); #1;
    chk("burst0_to_m1", {31'd0, grant_o}, 33'd2);
    for (int i = 0; i < 16; i++)
      do_read(1'b1, 32'h2000 + i, 32'hD000 + i, 2, 1'b0);
    chk("burst1_idle", {31'd0, grant_o}, 33'd0);
    @(posedge clk); #1;
    chk("burst1_to_m0", {31'd0, grant_o}, 33'd1);

    // early release by m1, en dropped during last read
    m0_en_i = 1'b0;
    do_read(1'b1, 32'h3000, 32'h1111_0000, 2, 1'b0);
    do_read(1'b1, 32'h3001, 32'h1111_0001, 3, 1'b0);
    do_read(1'b1, 32'h3002, 32'h1111_0002, 3, 1'b1);
    chk("early_release", {31'd0, grant_o}, 33'd0);
    m0_en_i = 1'b1; m1_en_i = 1'b1;
    @(posedge clk); #1;
    chk("ptr_to_m0", {31'd0, grant_o}, 33'd1);
    m0_en_i = 1'b0; m1_en_i = 1'b0;
    @(posedge clk); #1;

    // illegal strobes
    m0_en_i = 1'b1;
    wait_owner(1'b0, ok);
    n0 = rd_seen;
    m1_rd_i = 1'b1; m1_addr_i = 32'hDEAD;
    @(posedge clk); #1;
    m1_rd_i = 1'b0;
    chk("nonowner_rd_busy1", {32'd0, m1_busy_o}, 33'd1);
    chk("nonowner_rd_ignored", {32'd0, m0_busy_o},
        33'd0);
    ram_busy_i = 1'b1;
    #1;
    chk("owner_busy_follow", {32'd0, m0_busy_o}, 33'd1);
    m0_rd_i = 1'b1; m0_addr_i = 32'hBEEF;
    @(posedge clk); #1;
    m0_rd_i = 1'b0;
    ram_busy_i = 1'b0;
    #1;
    chk("busy_rd_ignored", {32'd0, m0_busy_o}, 33'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ram_rd_count", n0, rd_seen);
    chk("addr_held", {1'b0, ram_addr_o},
        33'h3002);
    do_read(1'b0, 32'h200, 32'h2222_2222, 1, 1'b0);

    // spurious rdata_rdy in idle
    m0_en_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_grant", {31'd0, grant_o}, 33'd0);
    ram_rdata_rdy_i = 1'b1;
    ram_rdata_i = 32'h7777_7777;
    #1;
    chk("idle_rdy", {31'd0, m1_rdata_rdy_o,
                     m0_rdata_rdy_o}, 33'd0);
    chk("rdata_passthru", {1'b0, m1_rdata_o},
        33'h7777_7777);
    @(posedge clk); #1;
    ram_rdata_rdy_i = 1'b0;
    chk("idle_hold", {31'd0, grant_o}, 33'd0);
    m1_en_i = 1'b1;
    @(posedge clk); #1;
    chk("idle_then_grant", {31'd0, grant_o}, 33'd2);
    m1_en_i = 1'b0;
    @(posedge clk); #1;

    // reset during WAIT
    m0_en_i = 1'b1;
    wait_owner(1'b0, ok);
    exp_rd.push_back(32'h300);
    m0_rd_i = 1'b1; m0_addr_i = 32'h300;
    @(posedge clk); #1;
    m0_rd_i = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    m0_en_i = 1'b0;
    #1;
    chk("mid_rst_grant", {31'd0, grant_o}, 33'd0);
    chk("mid_rst_busy", {31'd0, m1_busy_o, m0_busy_o},
        33'd3);
    chk("mid_rst_addr", {1'b0, ram_addr_o}, 33'd0);
    chk("mid_rst_rd", {32'd0, ram_rd_o}, 33'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    ram_rdata_rdy_i = 1'b1;
    ram_rdata_i = 32'h0000_005A;
    #1;
    chk("stale_rdy", {31'd0, m1_rdata_rdy_o,
                      m0_rdata_rdy_o}, 33'd0);
    @(posedge clk); #1;
    ram_rdata_rdy_i = 1'b0;
    chk("post_rst_grant", {31'd0, grant_o}, 33'd0);
    chk("post_rst_addr", {1'b0, ram_addr_o}, 33'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_rd_drained", exp_rd.size(), 33'd0);
    chk("exp_dat_drained", exp_dat.size(), 33'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
